memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/y86_pkg.sv | 28 ++
 rtl/data_memory.sv | 41 ++++
 rtl/memory_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encodings, register IDs
// and data-memory geometry used by the memory stage.
package y86_pkg;

    localparam int DATA_W    = 64;
    localparam int MEM_BYTES = 1024;
    localparam int MEM_AW    = 10;

    // Highest legal base address for an 8-byte access.
    localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(MEM_BYTES - 8);

    localparam logic [3:0] ICODE_HALT   = 4'd0;
    localparam logic [3:0] ICODE_NOP    = 4'd1;
    localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
    localparam logic [3:0] ICODE_CALL   = 4'd8;
    localparam logic [3:0] ICODE_RET    = 4'd9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
    localparam logic [3:0] ICODE_POPQ   = 4'd11;

    localparam logic [3:0] STAT_AOK = 4'b0001;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0100;
    localparam logic [3:0] STAT_INS = 4'b1000;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with 8-byte combinational reads,
// a clocked write port and an out-of-range check.
module data_memory
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              wr_ok,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              dmem_error
);

    logic [7:0]        mem [MEM_BYTES];
    logic [MEM_AW-1:0] base;

    assign base       = addr[MEM_AW-1:0];
    // Full 64-bit compare so wrapped addresses never alias into the array.
    assign dmem_error = (rd_en || wr_en) && (addr > MAX_ADDR);

    always_comb begin
        rd_data = '0;
        if (rd_en && !dmem_error) begin
            for (int i = 0; i < 8; i++) begin
                rd_data[8*i +: 8] = mem[base + MEM_AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok && !dmem_error && !reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + MEM_AW'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register with stall/bubble control,
// memory access decode and status update, feeding the W register.
module memory_stage
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        e_stat,
    input  logic [3:0]        e_icode,
    input  logic              e_cnd,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] e_valA,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic [3:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_cnd,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM,
    output logic [3:0]        m_stat,
    output logic [DATA_W-1:0] m_valM,
    output logic [3:0]        m_icode,
    output logic [DATA_W-1:0] m_valE,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM
);

    logic [DATA_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic              dmem_error;

    // Reset and bubble both insert a nop; bubble outranks stall.
    always_ff @(posedge clk) begin
        if (reset || M_bubble) begin
            M_stat  <= STAT_AOK;
            M_icode <= ICODE_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= e_dstM;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (M_icode)
            ICODE_RMMOVQ, ICODE_CALL, ICODE_PUSHQ: begin
                mem_addr = M_valE;
                mem_wr   = 1'b1;
            end
            ICODE_MRMOVQ: begin
                mem_addr = M_valE;
                mem_rd   = 1'b1;
            end
            // Stack pops address through the old stack pointer carried in valA.
            ICODE_RET, ICODE_POPQ: begin
                mem_addr = M_valA;
                mem_rd   = 1'b1;
            end
            default: ;
        endcase
    end

    data_memory u_dmem (
        .clk        (clk),
        .reset      (reset),
        .addr       (mem_addr),
        .rd_en      (mem_rd),
        .wr_en      (mem_wr),
        .wr_ok      (M_stat == STAT_AOK),
        .wr_data    (M_valA),
        .rd_data    (m_valM),
        .dmem_error (dmem_error)
    );

    assign m_stat  = dmem_error ? STAT_ADR : M_stat;
    assign m_icode = M_icode;
    assign m_valE  = M_valE;
    assign m_dstE  = M_dstE;
    assign m_dstM  = M_dstM;

endmodule
